hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4: multiply latency in cycles (legal range 1..255).
REQ-002 Parameter DIV_LAT, default 32: divide latency in cycles (legal range 1..255).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 IDoutrs  in  5  rs of the instruction in ID.
REQ-006 IDoutrt  in  5  rt of the instruction in ID.
REQ-007 IDuseRt  in  1  ID instruction reads rt as a source.
REQ-008 EXoutrd  in  5  destination register of the instruction in EX.
REQ-009 EXoutMemRead  in  1  EX instruction is a load.
REQ-010 branchTaken  in  1  branch/jump resolved taken in EX this cycle.
REQ-011 mduStart  in  1  ID instruction is mult/div.
REQ-012 mduIsDiv  in  1  qualifies mduStart: 1 = div, 0 = mult.
REQ-013 IDreadsHiLo  in  1  ID instruction is mfhi/mflo.
REQ-014 pcWrite  out  1  PC update enable.
REQ-015 ifidWrite  out  1  IF/ID register load enable.
REQ-016 ifidFlush  out  1  IF/ID register clear to NOP.
REQ-017 idexBubble  out  1  insert NOP into ID/EX.
REQ-018 mduBusy  out  1  multiply/divide unit occupied.
REQ-019 stallCnt  out  16  count of stall cycles.

Function
REQ-020 The block SHALL have states RUN and MDU_WAIT plus an 8-bit down-counter mduCnt.
REQ-021 loadUse SHALL be 1 when EXoutMemRead=1, EXoutrd!=0, and (EXoutrd==IDoutrs or (IDuseRt=1 and EXoutrd==IDoutrt)).
REQ-022 mduHaz SHALL be 1 when state=MDU_WAIT and (mduStart=1 or IDreadsHiLo=1).
REQ-023 Priority SHALL be branchTaken > loadUse > mduHaz, with outputs decoded combinationally in the same cycle.
REQ-024 When branchTaken=1, outputs SHALL be pcWrite=1, ifidWrite=1, ifidFlush=1, idexBubble=1.
REQ-025 Otherwise, when loadUse or mduHaz=1, outputs SHALL be pcWrite=0, ifidWrite=0, ifidFlush=0, idexBubble=1.
REQ-026 Otherwise, outputs SHALL be pcWrite=1, ifidWrite=1, ifidFlush=0, idexBubble=0.
REQ-027 In RUN, mduStart=1 with branchTaken=0 and loadUse=0 SHALL load mduCnt with (mduIsDiv ? DIV_LAT : MUL_LAT)-1 and move the state to MDU_WAIT.
REQ-028 In RUN, mduStart SHALL be ignored while branchTaken=1 or loadUse=1.
REQ-029 In MDU_WAIT, mduCnt SHALL decrement each cycle; in the cycle where mduCnt=0, the state SHALL return to RUN.
REQ-030 mduHaz SHALL apply in every MDU_WAIT cycle, including the cycle where mduCnt=0.
REQ-031 branchTaken in MDU_WAIT SHALL flush but SHALL NOT abort the counter, because the MDU op is older.
REQ-032 mduBusy SHALL equal (state==MDU_WAIT).
REQ-033 stallCnt SHALL increment in every cycle where pcWrite=0, saturating at 0xFFFF.

Reset
REQ-034 When rst=1 at a clock edge, state SHALL become RUN and mduCnt and stallCnt SHALL become 0, including when reset occurs mid MDU_WAIT.
REQ-035 During and after reset with all inputs 0, outputs SHALL be pcWrite=1, ifidWrite=1, ifidFlush=0, idexBubble=0, mduBusy=0, stallCnt=0.

Configuration
REQ-036 Macro MDU_STALL_EN defined: MDU tracking SHALL be present as specified.
REQ-037 Macro MDU_STALL_EN undefined: the state SHALL stay RUN, mduBusy SHALL be tied 0, mduHaz SHALL be 0, and mduStart, mduIsDiv and IDreadsHiLo SHALL be ignored; no MDU counter logic SHALL exist.

Verification
REQ-038 Load-use: EXoutMemRead=1, EXoutrd=8, IDoutrs=8 for one cycle -> pcWrite=0, ifidWrite=0, idexBubble=1 for that cycle; stallCnt goes 0->1.
REQ-039 No hazard on $0 or unused rt: EXoutrd=0 with IDoutrs=0, then EXoutrd=9 with IDoutrt=9 and IDuseRt=0 -> no stall in either case.
REQ-040 Multiply: mduStart=1, mduIsDiv=0 at cycle t, then IDreadsHiLo=1 from t+1 -> mduBusy=1 during t+1..t+4 with stall; pcWrite=1 and state RUN at t+5; stallCnt=4.
REQ-041 Flush priority: branchTaken=1 together with loadUse=1 -> ifidFlush=1, idexBubble=1, pcWrite=1; stallCnt unchanged; a concurrent mduStart is not accepted.
REQ-042 Divide with reset: rst=1 at t+10 after a divide start at t -> state RUN, mduBusy=0 and stallCnt=0 next cycle.
REQ-043 With MDU_STALL_EN undefined: mduStart=1, then IDreadsHiLo=1 -> mduBusy stays 0 and no stall occurs.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch flush, load-use stall and multiply/divide occupancy stall.
// Define MDU_STALL_EN to build the multiply/divide tracking FSM; without it the MDU inputs are ignored.
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IDoutrs,
    input  logic [4:0]  IDoutrt,
    input  logic        IDuseRt,
    input  logic [4:0]  EXoutrd,
    input  logic        EXoutMemRead,
    input  logic        branchTaken,
    input  logic        mduStart,
    input  logic        mduIsDiv,
    input  logic        IDreadsHiLo,
    output logic        pcWrite,
    output logic        ifidWrite,
    output logic        ifidFlush,
    output logic        idexBubble,
    output logic        mduBusy,
    output logic [15:0] stallCnt
);

    // Handshake note: there is no valid/ready pairing here; every output is a
    // same-cycle combinational decode of the current inputs and state.

    logic load_use;
    logic mdu_haz;

    assign load_use = EXoutMemRead && (EXoutrd != 5'd0) &&
                      ((EXoutrd == IDoutrs) || (IDuseRt && (EXoutrd == IDoutrt)));

`ifdef MDU_STALL_EN
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MDU_WAIT = 1'b1;

    logic [0:0] state;
    logic [7:0] mdu_cnt;

    // An MDU op already in flight is older than a taken branch, so the
    // counter keeps running through flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            mdu_cnt <= 8'd0;
        end else begin
            case (state)
                RUN: begin
                    if (mduStart && !branchTaken && !load_use) begin
                        mdu_cnt <= mduIsDiv ? 8'(DIV_LAT - 1) : 8'(MUL_LAT - 1);
                        state   <= MDU_WAIT;
                    end
                end
                MDU_WAIT: begin
                    if (mdu_cnt == 8'd0) begin
                        state <= RUN;
                    end else begin
                        mdu_cnt <= mdu_cnt - 8'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign mdu_haz = (state == MDU_WAIT) && (mduStart || IDreadsHiLo);
    assign mduBusy = (state == MDU_WAIT);
`else
    logic unused_mdu;

    assign unused_mdu = ^{mduStart, mduIsDiv, IDreadsHiLo, 8'(MUL_LAT), 8'(DIV_LAT)};
    assign mdu_haz    = 1'b0;
    assign mduBusy    = 1'b0;
`endif

    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        if (branchTaken) begin
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
        end else if (load_use || mdu_haz) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= 16'd0;
        end else if (!pcWrite && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end

endmodule
